// File: rtl/mch_tx_p2s_if.sv
// rtl/mch_tx_p2s_if.sv - start/payload handshake and line outputs of the Manchester frame transmitter
interface mch_tx_p2s_if;
  logic       pls2m;
  logic       start;
  logic [7:0] length;
  logic [7:0] pd0;
  logic [7:0] pd1;
  logic [7:0] pd2;
  logic [7:0] pd3;
  logic       busy;
  logic       done;
  logic       tx_en;
  logic       tx_sd;

  modport master (
    output pls2m, start, length, pd0, pd1, pd2, pd3,
    input  busy, done, tx_en, tx_sd
  );

  modport slave (
    input  pls2m, start, length, pd0, pd1, pd2, pd3,
    output busy, done, tx_en, tx_sd
  );
endinterface

// File: rtl/mch_tx_p2s.sv
// rtl/mch_tx_p2s.sv - Manchester frame transmitter: preamble, sync word and 8-byte body, MSB first
module mch_tx_p2s #(
  parameter int unsigned PRE_BITS  = 16,
  parameter logic [7:0]  SYNC_WORD = 8'h7E,
  parameter logic [7:0]  HDR       = 8'hCC,
  parameter logic [7:0]  PAD       = 8'h00
) (
  input logic         i_clk,
  input logic         i_rst,
  mch_tx_p2s_if.slave io_bus
);

  // Counter also indexes sync/body bits, so it is never narrower than 3 bits.
  localparam int CW = (PRE_BITS > 8) ? $clog2(PRE_BITS) : 3;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PRE  = 3'd2,
    S_SYNC = 3'd3,
    S_DATA = 3'd4
  } state_t;

  state_t        r_state;
  logic [63:0]   r_body;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_byte;
  logic          r_half;
  logic          r_busy;
  logic          r_done;
  logic          r_tx_en;
  logic          r_tx_sd;

  state_t        w_state;
  logic [63:0]   w_body;
  logic [CW-1:0] w_cnt;
  logic [2:0]    w_byte;
  logic          w_half;
  logic          w_busy;
  logic          w_done;
  logic          w_tx_en;
  logic          w_tx_sd;

  state_t        w_adv_state;
  logic [CW-1:0] w_adv_cnt;
  logic [2:0]    w_adv_byte;
  logic          w_last;
  logic          w_cur_bit;

  // Bit value at a frame position; cnt counts sent bits, so bit 7 of a byte goes first.
  function automatic logic frame_bit(state_t st, logic [2:0] cnt, logic [2:0] bidx,
                                     logic [63:0] body);
    logic [5:0] pos;
    pos = 6'd63 - {bidx, cnt};
    case (st)
      S_PRE:   frame_bit = ~cnt[0];
      S_SYNC:  frame_bit = SYNC_WORD[3'd7 - cnt];
      S_DATA:  frame_bit = body[pos];
      default: frame_bit = 1'b0;
    endcase
  endfunction

  assign w_cur_bit = frame_bit(r_state, r_cnt[2:0], r_byte, r_body);

  always_comb begin
    w_adv_state = r_state;
    w_adv_cnt   = r_cnt + CW'(1);
    w_adv_byte  = r_byte;
    w_last      = 1'b0;
    case (r_state)
      S_PRE: begin
        if (r_cnt == PRE_LAST) begin
          w_adv_state = S_SYNC;
          w_adv_cnt   = '0;
        end
      end
      S_SYNC: begin
        if (r_cnt[2:0] == 3'd7) begin
          w_adv_state = S_DATA;
          w_adv_cnt   = '0;
          w_adv_byte  = 3'd0;
        end
      end
      S_DATA: begin
        if (r_cnt[2:0] == 3'd7) begin
          if (r_byte == 3'd7) begin
            w_last = 1'b1;
          end else begin
            w_adv_cnt  = '0;
            w_adv_byte = r_byte + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_body  = r_body;
    w_cnt   = r_cnt;
    w_byte  = r_byte;
    w_half  = r_half;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_tx_en = r_tx_en;
    w_tx_sd = r_tx_sd;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_state = S_ARM;
          w_busy  = 1'b1;
          w_body  = {HDR, io_bus.length, io_bus.pd0, io_bus.pd1,
                     io_bus.pd2, io_bus.pd3, PAD, PAD};
        end
      end
      S_ARM: begin
        if (io_bus.pls2m) begin
          w_state = S_PRE;
          w_cnt   = '0;
          w_byte  = 3'd0;
          w_half  = 1'b0;
          w_tx_en = 1'b1;
          w_tx_sd = frame_bit(S_PRE, 3'd0, 3'd0, r_body);
        end
      end
      S_PRE, S_SYNC, S_DATA: begin
        if (io_bus.pls2m) begin
          if (!r_half) begin
            w_half  = 1'b1;
            w_tx_sd = ~w_cur_bit;
          end else if (w_last) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_byte  = 3'd0;
            w_half  = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_tx_en = 1'b0;
            w_tx_sd = 1'b0;
          end else begin
            // Second half done: step to the next bit and put its first half on the line.
            w_half  = 1'b0;
            w_state = w_adv_state;
            w_cnt   = w_adv_cnt;
            w_byte  = w_adv_byte;
            w_tx_sd = frame_bit(w_adv_state, w_adv_cnt[2:0], w_adv_byte, r_body);
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_tx_en = 1'b0;
        w_tx_sd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_body  <= '0;
      r_cnt   <= '0;
      r_byte  <= 3'd0;
      r_half  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tx_en <= 1'b0;
      r_tx_sd <= 1'b0;
    end else begin
      r_state <= w_state;
      r_body  <= w_body;
      r_cnt   <= w_cnt;
      r_byte  <= w_byte;
      r_half  <= w_half;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_tx_en <= w_tx_en;
      r_tx_sd <= w_tx_sd;
    end
  end

  assign io_bus.busy  = r_busy;
  assign io_bus.done  = r_done;
  assign io_bus.tx_en = r_tx_en;
  assign io_bus.tx_sd = r_tx_sd;

endmodule

// File: tb/tb_mch_tx_p2s.sv
// tb/tb_mch_tx_p2s.sv - randomized self-checking bench for mch_tx_p2s against a frame-level model
module tb_mch_tx_p2s;
  localparam int PRE_BITS = 16;
  localparam int FRAME_HB = 2 * (PRE_BITS + 8 + 64);
  localparam int BODY_BIT = PRE_BITS + 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mch_tx_p2s_if ifc ();

  mch_tx_p2s #(
    .PRE_BITS (PRE_BITS),
    .SYNC_WORD(8'h7E),
    .HDR      (8'hCC),
    .PAD      (8'h00)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   per = 4;
  int   per_cnt = 0;
  int   glitch_cnt = 0;
  int   done_cnt = 0;
  logic strobe_seen = 1'b0;
  logic rst_seen = 1'b0;
  logic prev_en = 1'b0;
  logic prev_sd = 1'b0;
  logic cap_q[$];
  logic exp_q[$];

  initial begin
    ifc.pls2m = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (per_cnt >= per - 1) per_cnt = 0;
      else per_cnt++;
      ifc.pls2m = (per_cnt == 0);
    end
  end

  always @(posedge clk) begin
    strobe_seen <= ifc.pls2m;
    rst_seen    <= rst;
  end

  // Line recorder: one sample per strobe while the driver is enabled.
  always @(negedge clk) begin
    if (!strobe_seen && rst_seen && (ifc.tx_en !== prev_en || ifc.tx_sd !== prev_sd))
      glitch_cnt++;
    if (strobe_seen && rst_seen && ifc.tx_en === 1'b1) cap_q.push_back(ifc.tx_sd);
    if (ifc.done === 1'b1) done_cnt++;
    prev_en = ifc.tx_en;
    prev_sd = ifc.tx_sd;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] len, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3);
    logic [7:0] bytes [9];
    logic v;
    exp_q.delete();
    for (int k = 0; k < PRE_BITS; k++) begin
      v = (k % 2 == 0);
      exp_q.push_back(v);
      exp_q.push_back(!v);
    end
    bytes = '{8'h7E, 8'hCC, len, p0, p1, p2, p3, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) begin
      for (int b = 7; b >= 0; b--) begin
        v = bytes[i][b];
        exp_q.push_back(v);
        exp_q.push_back(!v);
      end
    end
  endtask

  function automatic int first_diff();
    if (cap_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < cap_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int manch_errs();
    int e = 0;
    for (int i = 0; i + 1 < cap_q.size(); i += 2)
      if (cap_q[i] === cap_q[i+1]) e++;
    return e;
  endfunction

  function automatic logic [7:0] dec_byte(input int bitpos);
    logic [7:0] r = 8'h00;
    for (int j = 0; j < 8; j++)
      if (2 * (bitpos + j) < cap_q.size()) r[7-j] = cap_q[2*(bitpos+j)];
    return r;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 2000 && ifc.busy !== 1'b0; i++) tick();
  endtask

  task automatic start_frame(input logic [7:0] len, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3);
    ifc.start  = 1'b1;
    ifc.length = len;
    ifc.pd0 = p0; ifc.pd1 = p1; ifc.pd2 = p2; ifc.pd3 = p3;
    tick();
    ifc.start  = 1'b0;
    ifc.length = 8'($urandom);
    ifc.pd0 = 8'($urandom); ifc.pd1 = 8'($urandom);
    ifc.pd2 = 8'($urandom); ifc.pd3 = 8'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_HB * per + 64; i++) begin
      tick();
      if (ifc.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cap(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_HB * per + 64; i++) begin
      if (cap_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    int d0;
    int df;
    logic [7:0] b [5];
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", ifc.done); end
    n_checks++; if (ifc.tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en got=%b exp=0", ifc.tx_en); end
    n_checks++; if (ifc.tx_sd !== 1'b0) begin n_fail++; $display("FAIL reset_tx_sd got=%b exp=0", ifc.tx_sd); end

    start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (70) tick();
    d0 = done_cnt;
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({ifc.busy, ifc.done, ifc.tx_en, ifc.tx_sd} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%b exp=0000", {ifc.busy, ifc.done, ifc.tx_en, ifc.tx_sd});
    end
    rst = 1'b1;
    repeat (20) tick();
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=%0d", done_cnt - d0, 0); end

    foreach (b[i]) b[i] = 8'($urandom);
    model_frame(b[0], b[1], b[2], b[3], b[4]);
    cap_q.delete();
    start_frame(b[0], b[1], b[2], b[3], b[4]);
    wait_done(ok);
    df = first_diff();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL postreset_done got=timeout exp=done"); end
    n_checks++; if (df != -1) begin n_fail++; $display("FAIL postreset_frame got=diff@%0d exp=-1", df); end
  endtask

  task automatic test_basic_frame();
    bit ok;
    int d0;
    int df;
    per = 4;
    wait_idle();
    repeat (8) tick();
    d0 = done_cnt;
    model_frame(8'h04, 8'h11, 8'h22, 8'h33, 8'h44);
    cap_q.delete();
    start_frame(8'h04, 8'h11, 8'h22, 8'h33, 8'h44);
    wait_done(ok);
    repeat (3) tick();
    df = first_diff();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done got=timeout exp=done"); end
    n_checks++; if (cap_q.size() != FRAME_HB) begin n_fail++; $display("FAIL basic_halfbits got=%0d exp=%0d", cap_q.size(), FRAME_HB); end
    n_checks++; if (df != -1) begin n_fail++; $display("FAIL basic_frame got=diff@%0d exp=-1", df); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
    n_checks++; if (dec_byte(PRE_BITS) !== 8'h7E) begin n_fail++; $display("FAIL basic_sync got=%h exp=7e", dec_byte(PRE_BITS)); end
    n_checks++; if (dec_byte(BODY_BIT + 8) !== 8'h04) begin n_fail++; $display("FAIL basic_length got=%h exp=04", dec_byte(BODY_BIT + 8)); end
    n_checks++;
    if ({dec_byte(BODY_BIT + 16), dec_byte(BODY_BIT + 24), dec_byte(BODY_BIT + 32), dec_byte(BODY_BIT + 40)} !== 32'h11223344) begin
      n_fail++;
      $display("FAIL basic_payload got=%h exp=11223344",
               {dec_byte(BODY_BIT + 16), dec_byte(BODY_BIT + 24), dec_byte(BODY_BIT + 32), dec_byte(BODY_BIT + 40)});
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    int df;
    int me;
    logic [7:0] b [5];
    for (int f = 0; f < 3; f++) begin
      wait_idle();
      per = $urandom_range(2, 6);
      repeat (8) tick();
      foreach (b[i]) b[i] = 8'($urandom);
      model_frame(b[0], b[1], b[2], b[3], b[4]);
      cap_q.delete();
      start_frame(b[0], b[1], b[2], b[3], b[4]);
      wait_done(ok);
      df = first_diff();
      me = manch_errs();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_done got=timeout exp=done per=%0d", f, per); end
      n_checks++; if (df != -1) begin n_fail++; $display("FAIL rand%0d_frame got=diff@%0d exp=-1 per=%0d", f, df, per); end
      n_checks++; if (me != 0) begin n_fail++; $display("FAIL rand%0d_manchester got=%0d exp=0", f, me); end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    bit okc;
    int d0;
    int df;
    int drops = 0;
    logic [7:0] b [5];
    per = 4;
    wait_idle();
    repeat (8) tick();
    foreach (b[i]) b[i] = 8'($urandom);
    model_frame(b[0], b[1], b[2], b[3], b[4]);
    cap_q.delete();
    d0 = done_cnt;
    start_frame(b[0], b[1], b[2], b[3], b[4]);
    wait_cap(60, okc);
    ifc.start = 1'b1;
    ifc.length = 8'hFF;
    ifc.pd0 = 8'hAA; ifc.pd1 = 8'hAA; ifc.pd2 = 8'hAA; ifc.pd3 = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ifc.busy !== 1'b1) drops++;
    end
    ifc.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < FRAME_HB * per + 64; i++) begin
      tick();
      if (ifc.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (ifc.busy !== 1'b1) drops++;
    end
    repeat (3) tick();
    df = first_diff();
    n_checks++; if (!(ok && okc)) begin n_fail++; $display("FAIL busy_start_progress got=timeout exp=done"); end
    n_checks++; if (df != -1) begin n_fail++; $display("FAIL busy_start_frame got=diff@%0d exp=-1", df); end
    n_checks++; if (drops != 0) begin n_fail++; $display("FAIL busy_start_busy_held got=%0d drops exp=0", drops); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL busy_start_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_start_on_strobe();
    bit ok;
    int early = 0;
    int df;
    logic [7:0] b [5];
    per = 5;
    wait_idle();
    repeat (8) tick();
    for (int i = 0; i < 20 && ifc.pls2m !== 1'b1; i++) tick();
    foreach (b[i]) b[i] = 8'($urandom);
    model_frame(b[0], b[1], b[2], b[3], b[4]);
    cap_q.delete();
    start_frame(b[0], b[1], b[2], b[3], b[4]);
    for (int i = 0; i < per; i++) begin
      if (ifc.tx_en !== 1'b0) early++;
      tick();
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL strobe_start_early got=%0d exp=0", early); end
    n_checks++; if (ifc.tx_en !== 1'b1) begin n_fail++; $display("FAIL strobe_start_rise got=%b exp=1", ifc.tx_en); end
    wait_done(ok);
    df = first_diff();
    n_checks++; if (!ok || df != -1) begin n_fail++; $display("FAIL strobe_start_frame got=diff@%0d ok=%0d exp=-1", df, ok); end
  endtask

  task automatic test_reset_mid_frame();
    bit okc;
    int d0;
    per = 4;
    wait_idle();
    repeat (8) tick();
    cap_q.delete();
    d0 = done_cnt;
    start_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    wait_cap(50, okc);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (ifc.tx_en !== 1'b0) begin n_fail++; $display("FAIL rst1_tx_en got=%b exp=0", ifc.tx_en); end
    n_checks++; if (ifc.tx_sd !== 1'b0) begin n_fail++; $display("FAIL rst1_tx_sd got=%b exp=0", ifc.tx_sd); end
    n_checks++; if (ifc.busy !== 1'b0 || !okc) begin n_fail++; $display("FAIL rst1_busy got=%b exp=0", ifc.busy); end
    repeat (60) tick();
    n_checks++; if (done_cnt != d0 || ifc.tx_en !== 1'b0) begin n_fail++; $display("FAIL rst1_no_done got=%0d en=%b exp=0", done_cnt - d0, ifc.tx_en); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int dfa = -3;
    int dfb;
    int meb;
    int low = 0;
    logic busy_at_done = 1'b1;
    logic [7:0] a [5];
    logic [7:0] b [5];
    per = $urandom_range(3, 5);
    wait_idle();
    repeat (8) tick();
    foreach (a[i]) a[i] = 8'($urandom);
    foreach (b[i]) b[i] = 8'($urandom);
    model_frame(a[0], a[1], a[2], a[3], a[4]);
    cap_q.delete();
    start_frame(a[0], a[1], a[2], a[3], a[4]);
    wait_done(ok);
    if (ok) begin
      busy_at_done = ifc.busy;
      dfa = first_diff();
      if (ifc.tx_en === 1'b0) low++;
      cap_q.delete();
      model_frame(b[0], b[1], b[2], b[3], b[4]);
      start_frame(b[0], b[1], b[2], b[3], b[4]);
      for (int i = 0; i < 4 * per && ifc.tx_en !== 1'b1; i++) begin
        low++;
        tick();
      end
      wait_done(ok);
    end
    dfb = first_diff();
    meb = manch_errs();
    n_checks++; if (dfa != -1) begin n_fail++; $display("FAIL b2b_first_frame got=diff@%0d exp=-1", dfa); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_at_done got=%b exp=0", busy_at_done); end
    n_checks++; if (low != per) begin n_fail++; $display("FAIL b2b_gap got=%0d clks exp=%0d", low, per); end
    n_checks++; if (!ok || dfb != -1) begin n_fail++; $display("FAIL b2b_second_frame got=diff@%0d ok=%0d exp=-1", dfb, ok); end
    n_checks++; if (meb != 0 || cap_q.size() != FRAME_HB) begin n_fail++; $display("FAIL b2b_manchester got=%0d errs size=%0d exp=0", meb, cap_q.size()); end
  endtask

  task automatic test_line_stability();
    n_checks++; if (glitch_cnt != 0) begin n_fail++; $display("FAIL line_changes_off_strobe got=%0d exp=0", glitch_cnt); end
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.length = 8'h00;
    ifc.pd0 = 8'h00; ifc.pd1 = 8'h00; ifc.pd2 = 8'h00; ifc.pd3 = 8'h00;
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_start_while_busy();
    test_start_on_strobe();
    test_reset_mid_frame();
    test_back_to_back();
    test_line_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
